// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: ALU op codes, FSM states
// and the divider iteration count.
package hilo_muldiv_pkg;

  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  localparam int HILO_DIV_ITERS = 32;

  typedef enum logic [1:0] {
    HILO_IDLE = 2'd0,
    HILO_MUL  = 2'd1,
    HILO_DIV  = 2'd2,
    HILO_DONE = 2'd3
  } hilo_state_e;

endpackage

// File: rtl/hilo_muldiv_unit_div_radix2_iter.sv
// One restoring radix-2 division step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_radix2_iter #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] dvsr,
  output logic [W-1:0] rem_nxt,
  output logic [W-1:0] quo_nxt
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // Remainder stays below the divisor, so the top bit of diff is a clean borrow flag.
  assign shifted = {rem, quo[W-1]};
  assign diff    = shifted - {1'b0, dvsr};
  assign rem_nxt = diff[W] ? shifted[W-1:0] : diff[W-1:0];
  assign quo_nxt = {quo[W-2:0], ~diff[W]};

endmodule

// File: rtl/hilo_muldiv_unit.sv
// E-stage HI/LO unit: owns HI/LO, runs multi-cycle MULT/DIV behind a pipeline
// stall, and serves MTHI/MTLO/MFHI/MFLO.
module hilo_muldiv_unit
  import hilo_muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid_i,
  input  logic [7:0]        alucontrol_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  hilo_state_e         state;
  logic [4:0]          cnt;
  logic [2*DATA_W-1:0] acc;    // product, or {remainder, quotient} while dividing
  logic [DATA_W-1:0]   dvsr;
  logic [DATA_W-1:0]   hi, lo;
  logic                op_div, neg_q, neg_r;

  logic                is_mul, is_div, sgn, issue;
  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   abs_a, abs_b, rem_nxt, quo_nxt, quo_fix, rem_fix;
  logic [2*DATA_W-1:0] ext_a, ext_b;

  assign is_mul = alucontrol_i inside {EXE_MULT_OP, EXE_MULTU_OP};
  assign is_div = alucontrol_i inside {EXE_DIV_OP, EXE_DIVU_OP};
  assign sgn    = alucontrol_i inside {EXE_MULT_OP, EXE_DIV_OP};
  assign issue  = valid_i & ~flush_i & (state == HILO_IDLE) & (is_mul | is_div);

  assign stall_o = ~flush_i & (issue | state == HILO_MUL | state == HILO_DIV);

  // Low 64 bits of the extended product are correct for both signednesses.
  assign a_neg = sgn & a_i[DATA_W-1];
  assign b_neg = sgn & b_i[DATA_W-1];
  assign ext_a = {{DATA_W{a_neg}}, a_i};
  assign ext_b = {{DATA_W{b_neg}}, b_i};
  assign abs_a = a_neg ? -a_i : a_i;
  assign abs_b = b_neg ? -b_i : b_i;

  div_radix2_iter #(.W(DATA_W)) u_iter (
    .rem     (acc[2*DATA_W-1:DATA_W]),
    .quo     (acc[DATA_W-1:0]),
    .dvsr    (dvsr),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  assign quo_fix = neg_q ? -acc[DATA_W-1:0]        : acc[DATA_W-1:0];
  assign rem_fix = neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= HILO_IDLE;
      cnt    <= '0;
      acc    <= '0;
      dvsr   <= '0;
      hi     <= '0;
      lo     <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (flush_i) begin
      state <= HILO_IDLE;
    end else begin
      unique case (state)
        HILO_IDLE: begin
          if (issue && is_mul) begin
            acc    <= ext_a * ext_b;
            cnt    <= 5'(MUL_CYCLES - 1);
            op_div <= 1'b0;
            state  <= HILO_MUL;
          end else if (issue) begin
            acc    <= {{DATA_W{1'b0}}, abs_a};
            dvsr   <= abs_b;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            cnt    <= 5'(HILO_DIV_ITERS - 1);
            op_div <= 1'b1;
            state  <= HILO_DIV;
          end else if (valid_i) begin
            if (alucontrol_i == EXE_MTHI_OP) hi <= a_i;
            if (alucontrol_i == EXE_MTLO_OP) lo <= a_i;
          end
        end
        HILO_MUL: begin
          if (cnt == 5'd0) state <= HILO_DONE;
          else             cnt   <= cnt - 5'd1;
        end
        HILO_DIV: begin
          acc <= {rem_nxt, quo_nxt};
          if (cnt == 5'd0) state <= HILO_DONE;
          else             cnt   <= cnt - 5'd1;
        end
        HILO_DONE: begin
          hi    <= op_div ? rem_fix : acc[2*DATA_W-1:DATA_W];
          lo    <= op_div ? quo_fix : acc[DATA_W-1:0];
          state <= HILO_IDLE;
        end
      endcase
    end
  end

  // NOTE: result_o gets a default before the case so no latch is inferred.
  always_comb begin
    result_o = '0;
    case (alucontrol_i)
      EXE_MFHI_OP: result_o = hi;
      EXE_MFLO_OP: result_o = lo;
      default:     ;
    endcase
  end

  assign hi_o = hi;
  assign lo_o = lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: each instruction pushes its expected
// stall length, result and post-commit HI/LO; a monitor checks at retirement.
module tb_hilo_muldiv_unit;
  import hilo_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_i;
  logic [7:0]  alucontrol_i;
  logic [31:0] a_i, b_i;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] result_o, hi_o, lo_o;

  hilo_muldiv_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .valid_i      (valid_i),
    .alucontrol_i (alucontrol_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .result_o     (result_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    int          stall;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: an instruction retires from E on a cycle with valid_i high and stall_o low.
  initial begin : monitor
    int   run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        run = 0;
      end else if (valid_i && stall_o) begin
        run++;
      end else if (valid_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check({e.nm, "_stall"}, 32'(run), 32'(e.stall));
          check({e.nm, "_result"}, result_o, e.res);
          @(posedge clk);
          #1;
          check({e.nm, "_hi"}, hi_o, e.hi);
          check({e.nm, "_lo"}, lo_o, e.lo);
        end
        run = 0;
      end
    end
  end

  // Issue one instruction at posedge+1, optionally flush after flush_at edges,
  // hold it until it retires, then drop valid after the retiring edge.
  task automatic op(input string nm, input logic [7:0] code, input logic [31:0] a,
                    input logic [31:0] b, input int flush_at, input int stall,
                    input logic [31:0] res, input logic [31:0] hi, input logic [31:0] lo);
    bit done;
    exp_q.push_back('{nm, stall, res, hi, lo});
    valid_i      = 1'b1;
    alucontrol_i = code;
    a_i          = a;
    b_i          = b;
    if (flush_at >= 0) begin
      repeat (flush_at) @(posedge clk);
      #1 flush_i = 1'b1;
    end
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!stall_o) done = 1'b1;
    end
    if (!done) check({nm, "_timeout"}, 32'd1, 32'd0);
    @(posedge clk);
    #1;
    valid_i      = 1'b0;
    flush_i      = 1'b0;
    alucontrol_i = 8'h00;
  endtask

  initial begin : stimulus
    resetn       = 1'b0;
    valid_i      = 1'b0;
    flush_i      = 1'b0;
    alucontrol_i = 8'h00;
    a_i          = '0;
    b_i          = '0;
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_result", result_o, 32'h0);
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    #10 resetn = 1'b1;
    @(posedge clk);
    #1;

    op("mult",     EXE_MULT_OP,  32'hFFFF_FFFE, 32'd3, -1, 3, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    op("multu",    EXE_MULTU_OP, 32'hFFFF_FFFE, 32'd3, -1, 3, 32'h0, 32'h0000_0002, 32'hFFFF_FFFA);
    op("div_neg",  EXE_DIV_OP,   32'hFFFF_FFF9, 32'd2, -1, 33, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    op("divu_z",   EXE_DIVU_OP,  32'd7, 32'd0, -1, 33, 32'h0, 32'h0000_0007, 32'hFFFF_FFFF);
    op("div_ovf",  EXE_DIV_OP,   32'h8000_0000, 32'hFFFF_FFFF, -1, 33, 32'h0, 32'h0, 32'h8000_0000);
    op("divu",     EXE_DIVU_OP,  32'd100, 32'd7, -1, 33, 32'h0, 32'd2, 32'd14);
    op("div_nb",   EXE_DIV_OP,   32'd7, 32'hFFFF_FFFE, -1, 33, 32'h0, 32'd1, 32'hFFFF_FFFD);
    op("mthi",     EXE_MTHI_OP,  32'h1234_5678, 32'h0, -1, 0, 32'h0, 32'h1234_5678, 32'hFFFF_FFFD);
    op("mfhi",     EXE_MFHI_OP,  32'h0, 32'h0, -1, 0, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFD);
    op("mtlo_fl",  EXE_MTLO_OP,  32'hDEAD_BEEF, 32'h0, 0, 0, 32'h0, 32'h1234_5678, 32'hFFFF_FFFD);
    op("mthi1",    EXE_MTHI_OP,  32'h1111_1111, 32'h0, -1, 0, 32'h0, 32'h1111_1111, 32'hFFFF_FFFD);
    op("mtlo1",    EXE_MTLO_OP,  32'h1111_1111, 32'h0, -1, 0, 32'h0, 32'h1111_1111, 32'h1111_1111);
    op("div_fl",   EXE_DIV_OP,   32'd1000, 32'd3, 10, 10, 32'h0, 32'h1111_1111, 32'h1111_1111);
    op("mflo",     EXE_MFLO_OP,  32'h0, 32'h0, -1, 0, 32'h1111_1111, 32'h1111_1111, 32'h1111_1111);
    op("other",    8'h20,        32'hAAAA_AAAA, 32'h5, -1, 0, 32'h0, 32'h1111_1111, 32'h1111_1111);

    // Reset dropped asynchronously in the middle of a divide.
    valid_i      = 1'b1;
    alucontrol_i = EXE_DIV_OP;
    a_i          = 32'd50;
    b_i          = 32'd5;
    repeat (6) @(posedge clk);
    #3;
    check("mid_div_stall_pre", 32'(stall_o), 32'd1);
    resetn  = 1'b0;
    valid_i = 1'b0;
    #1;
    check("arst_stall", 32'(stall_o), 32'd0);
    check("arst_hi", hi_o, 32'h0);
    check("arst_lo", lo_o, 32'h0);
    @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;

    op("post_mfhi",  EXE_MFHI_OP,  32'h0, 32'h0, -1, 0, 32'h0, 32'h0, 32'h0);
    op("post_multu", EXE_MULTU_OP, 32'd5, 32'd6, -1, 3, 32'h0, 32'h0, 32'd30);

    repeat (3) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
